imem_loader_fetch: RTL and testbench

Parametrised instruction memory for the pipelined RV64 core, and the successor to the combinational byte-array instruction memory. It provides:
- a registered, stall-aware fetch port with one-cycle latency and fault reporting;
- a byte-serial program-load port, so programs such as bubble sort and the forwarding/hazard tests are streamed in at run time instead of being hard-coded.

It sits between the IF-stage PC register and the IF/ID pipeline register.

---
 rtl/imem_loader_fetch.sv | 238 +++++++++++++++++++++++
 tb/tb_imem_loader_fetch.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader_fetch.sv
// -----------------------------------------------------------------------------
// imem_loader_fetch
//
// Instruction memory for the pipelined RV64 core. It sits between the IF-stage
// PC register and the IF/ID pipeline register.
//   * Fetch port: registered, one-cycle latency, stall-aware, reports faults.
//   * Load port: byte-serial program loader. Bytes arrive in ascending address
//     order starting at byte address 0. They are assembled into little-endian
//     32-bit words before being written.
//
// Optional feature macro: IMEM_BOUNDS_CHECK_EN
//   defined   : a fetch at or beyond DEPTH_WORDS*4 faults and returns NOP_WORD.
//   undefined : the word index wraps modulo the memory size. Only a
//               misaligned fetch faults.
//
// Parameters:
//   DEPTH_WORDS : number of 32-bit words (a power of two, at least 4)
//   ADDR_W      : width of the fetch byte address
//   NOP_WORD    : word returned on a fault or an empty fetch
//
// Ports:
//   clk, reset_n    : clock, synchronous active-low reset
//   fetch_req       : fetch request for fetch_addr
//   fetch_addr      : fetch byte address (PC)
//   fetch_stall     : freeze the fetch outputs and ignore fetch_req
//   instruction     : fetched word
//   inst_valid      : instruction holds a completed fetch
//   inst_fault      : the completed fetch was misaligned or out of range
//   ld_start        : begin a program load at byte address 0
//   ld_valid        : ld_byte is valid
//   ld_byte         : program byte
//   ld_last         : final byte of the load
//   ld_ready        : loader accepts a byte this cycle
//   ld_busy         : load in progress; fetch is blocked
//   ld_done         : one-cycle pulse when a load completes
//   ld_err          : sticky; a byte was dropped past the end of memory
// -----------------------------------------------------------------------------
module imem_loader_fetch #(
  parameter int          DEPTH_WORDS = 64,
  parameter int          ADDR_W      = 64,
  parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_stall,
  output logic [31:0]       instruction,
  output logic              inst_valid,
  output logic              inst_fault,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [7:0]        ld_byte,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              ld_done,
  output logic              ld_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  // The pointer has one spare bit so that it can hold DEPTH_WORDS*4, the first
  // out-of-range byte address. It saturates there.
  localparam int PTR_W = IDX_W + 3;
  localparam logic [PTR_W-1:0] PTR_LIMIT = PTR_W'(DEPTH_WORDS * 4);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } ld_state_t;

  ld_state_t        state_r;
  ld_state_t        state_next_s;

  logic [PTR_W-1:0] ptr_r;
  logic [31:0]      buf_r;
  logic [31:0]      mem_r [DEPTH_WORDS];

  logic             ld_ready_r;
  logic             ld_busy_r;
  logic             ld_done_r;
  logic             ld_err_r;
  logic [31:0]      instruction_r;
  logic             inst_valid_r;
  logic             inst_fault_r;

  logic             byte_acc_s;
  logic             in_range_s;
  logic [1:0]       lane_s;
  logic [31:0]      word_s;
  logic             wr_en_s;
  logic             drop_s;

  logic [IDX_W-1:0] fetch_idx_s;
  logic             misalign_s;
  logic             oob_s;
  logic             fault_s;

  assign ld_ready    = ld_ready_r;
  assign ld_busy     = ld_busy_r;
  assign ld_done     = ld_done_r;
  assign ld_err      = ld_err_r;
  assign instruction = instruction_r;
  assign inst_valid  = inst_valid_r;
  assign inst_fault  = inst_fault_r;

  // Loader next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (ld_start) begin
          state_next_s = ST_LOAD;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // A restart request while loading is ignored.
        if (byte_acc_s && ld_last) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_LOAD;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Loader state register and registered status outputs, decoded from the
  // next state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      ld_ready_r <= 1'b0;
      ld_busy_r  <= 1'b0;
      ld_done_r  <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      ld_ready_r <= (state_next_s == ST_LOAD);
      ld_busy_r  <= (state_next_s == ST_LOAD);
      ld_done_r  <= (state_next_s == ST_DONE);
    end
  end

  // Byte assembly: merge the incoming byte into its lane. On the last byte,
  // zero the lanes above it.
  always_comb begin
    byte_acc_s = ld_valid && ld_ready_r;
    in_range_s = (ptr_r < PTR_LIMIT);
    lane_s     = ptr_r[1:0];
    word_s     = buf_r;
    word_s[{lane_s, 3'b000} +: 8] = ld_byte;
    for (int i = 0; i < 4; i++) begin
      if (ld_last && (i > int'(lane_s))) begin
        word_s[8*i +: 8] = 8'h00;
      end else begin
        word_s[8*i +: 8] = word_s[8*i +: 8];
      end
    end
    // Writes are suppressed at a reset edge so that an aborted load leaves
    // memory untouched.
    wr_en_s = reset_n && byte_acc_s && in_range_s &&
              ((lane_s == 2'd3) || ld_last);
    drop_s  = byte_acc_s && !in_range_s;
  end

  // Loader pointer, assembly buffer and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr_r    <= '0;
      buf_r    <= 32'h0000_0000;
      ld_err_r <= 1'b0;
    end else if ((state_r == ST_IDLE) && ld_start) begin
      ptr_r    <= '0;
      buf_r    <= 32'h0000_0000;
      ld_err_r <= 1'b0;
    end else if (byte_acc_s) begin
      if (in_range_s) begin
        ptr_r <= ptr_r + PTR_W'(1);
        // After a word is written, the buffer restarts from zero.
        buf_r <= wr_en_s ? 32'h0000_0000 : word_s;
      end else begin
        ptr_r <= ptr_r;
        buf_r <= buf_r;
      end
      ld_err_r <= ld_err_r | drop_s;
    end else begin
      ptr_r    <= ptr_r;
      buf_r    <= buf_r;
      ld_err_r <= ld_err_r;
    end
  end

  // Memory write port. Contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[ptr_r[IDX_W+1:2]] <= word_s;
    end
  end

  // Fetch address decode and fault classification.
  always_comb begin
    fetch_idx_s = fetch_addr[IDX_W+1:2];
    misalign_s  = (fetch_addr[1:0] != 2'b00);
`ifdef IMEM_BOUNDS_CHECK_EN
    oob_s       = (fetch_addr >= ADDR_W'(DEPTH_WORDS * 4));
`else
    oob_s       = 1'b0;
`endif
    fault_s     = misalign_s || oob_s;
  end

  // Registered fetch port. A stall freezes the outputs. A fetch blocked by a
  // load, or no request at all, yields an empty NOP slot.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      instruction_r <= NOP_WORD;
      inst_valid_r  <= 1'b0;
      inst_fault_r  <= 1'b0;
    end else if (fetch_stall) begin
      instruction_r <= instruction_r;
      inst_valid_r  <= inst_valid_r;
      inst_fault_r  <= inst_fault_r;
    end else if (fetch_req && !ld_busy_r) begin
      instruction_r <= fault_s ? NOP_WORD : mem_r[fetch_idx_s];
      inst_valid_r  <= 1'b1;
      inst_fault_r  <= fault_s;
    end else begin
      instruction_r <= NOP_WORD;
      inst_valid_r  <= 1'b0;
      inst_fault_r  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imem_loader_fetch.sv
// -----------------------------------------------------------------------------
// Testbench for imem_loader_fetch, with a 4-word memory so that the overflow
// path is reachable. The bench keeps a model of the memory contents, and a
// queue holds expected fetch results until the DUT produces them.
// -----------------------------------------------------------------------------
module tb_imem_loader_fetch;

  localparam int          DW  = 4;
  localparam int          AW  = 64;
  localparam logic [31:0] NOP = 32'h00000013;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_stall;
  logic [31:0]   instruction;
  logic          inst_valid;
  logic          inst_fault;
  logic          ld_start;
  logic          ld_valid;
  logic [7:0]    ld_byte;
  logic          ld_last;
  logic          ld_ready;
  logic          ld_busy;
  logic          ld_done;
  logic          ld_err;

  imem_loader_fetch #(
    .DEPTH_WORDS(DW),
    .ADDR_W     (AW),
    .NOP_WORD   (NOP)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_stall(fetch_stall),
    .instruction(instruction),
    .inst_valid (inst_valid),
    .inst_fault (inst_fault),
    .ld_start   (ld_start),
    .ld_valid   (ld_valid),
    .ld_byte    (ld_byte),
    .ld_last    (ld_last),
    .ld_ready   (ld_ready),
    .ld_busy    (ld_busy),
    .ld_done    (ld_done),
    .ld_err     (ld_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic        valid;
    logic        fault;
  } exp_t;

  exp_t        sb_q[$];
  logic [7:0]  load_q[$];
  logic [31:0] model_mem [DW];
  logic [31:0] mbuf;
  int          mptr;
  logic        merr;
  int          checks = 0;
  int          fails  = 0;

  // Expected result of an accepted fetch, based on the bench's memory model.
  function automatic exp_t predict(input logic [AW-1:0] a);
    exp_t e;
    e.valid = 1'b1;
    e.fault = (a[1:0] != 2'b00);
`ifdef IMEM_BOUNDS_CHECK_EN
    if (a >= AW'(DW * 4)) e.fault = 1'b1;
`endif
    e.instr = e.fault ? NOP : model_mem[int'((a >> 2) % DW)];
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_fetch(input logic [AW-1:0] a, input exp_t e);
    fetch_req   = 1'b1;
    fetch_stall = 1'b0;
    fetch_addr  = a;
    sb_q.push_back(e);
  endtask

  // Streams load_q[0..n-1] through the loader and updates the model. A restart
  // request is raised on byte 1; the loader must ignore it. A fetch held
  // during the load must come back as an empty slot.
  task automatic load_stream(input int n, input bit do_last, input bit fetch_on_start);
    exp_t e;
    ld_start = 1'b1;
    if (fetch_on_start) push_fetch('0, predict('0));
    else fetch_req = 1'b0;
    step();
    ld_start = 1'b0;
    if (fetch_on_start) begin
      e = sb_q.pop_front();
      checks++;
      if ({instruction, inst_valid, inst_fault} !== {e.instr, e.valid, e.fault}) begin
        fails++;
        $display("FAIL fetch_with_start: got %h/%b/%b expected %h/%b/%b",
                 instruction, inst_valid, inst_fault, e.instr, e.valid, e.fault);
      end
    end
    checks++;
    if ({ld_busy, ld_ready, ld_err, ld_done} !== 4'b1100) begin
      fails++;
      $display("FAIL load_started: busy/ready/err/done got %b%b%b%b expected 1100",
               ld_busy, ld_ready, ld_err, ld_done);
    end
    mptr = 0; mbuf = 32'h0; merr = 1'b0;
    fetch_req  = 1'b1;
    fetch_addr = '0;
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1;
      ld_byte  = load_q[i];
      ld_last  = do_last && (i == n - 1);
      ld_start = (i == 1);
      step();
      if (mptr < DW * 4) begin
        mbuf[8*(mptr%4) +: 8] = load_q[i];
        if (((mptr % 4) == 3) || ld_last) begin
          model_mem[mptr/4] = mbuf;
          mbuf = 32'h0;
        end
        mptr++;
      end else begin
        merr = 1'b1;
      end
      checks++;
      if ({instruction, inst_valid, inst_fault} !== {NOP, 1'b0, 1'b0}) begin
        fails++;
        $display("FAIL fetch_blocked: got %h/%b/%b expected %h/0/0",
                 instruction, inst_valid, inst_fault, NOP);
      end
    end
    ld_valid = 1'b0; ld_last = 1'b0; ld_start = 1'b0; fetch_req = 1'b0;
    if (do_last) begin
      checks++;
      if ({ld_done, ld_busy, ld_ready, ld_err} !== {1'b1, 1'b0, 1'b0, merr}) begin
        fails++;
        $display("FAIL load_done: done/busy/ready/err got %b%b%b%b expected 100%b",
                 ld_done, ld_busy, ld_ready, ld_err, merr);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; fetch_req = 1'b0; fetch_addr = '0; fetch_stall = 1'b0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_byte = 8'h00; ld_last = 1'b0;
    step(); step();
    checks++;
    if ({instruction, inst_valid, inst_fault, ld_ready, ld_busy, ld_done, ld_err}
        !== {NOP, 6'b000000}) begin
      fails++;
      $display("FAIL reset_state: got %h/%b%b%b%b%b%b expected %h/000000", instruction,
               inst_valid, inst_fault, ld_ready, ld_busy, ld_done, ld_err, NOP);
    end
    reset_n = 1'b1;
    step();
    checks++;
    if ({instruction, inst_valid, inst_fault, ld_ready, ld_busy, ld_done, ld_err}
        !== {NOP, 6'b000000}) begin
      fails++;
      $display("FAIL idle_state: got %h/%b%b%b%b%b%b expected %h/000000", instruction,
               inst_valid, inst_fault, ld_ready, ld_busy, ld_done, ld_err, NOP);
    end
  endtask

  task automatic test_load_basic();
    exp_t e;
    load_q = '{8'h93, 8'h02, 8'h00, 8'h10, 8'h13, 8'h03, 8'h70, 8'h00};
    load_stream(8, 1'b1, 1'b0);
    // Earliest fetch: sampled at the edge that ends the DONE cycle.
    push_fetch(64'd0, '{32'h10000293, 1'b1, 1'b0});
    step();
    checks++;
    if (ld_done !== 1'b0) begin
      fails++;
      $display("FAIL done_single_pulse: got %b expected 0", ld_done);
    end
    e = sb_q.pop_front();
    checks++;
    if ({instruction, inst_valid, inst_fault} !== {e.instr, e.valid, e.fault}) begin
      fails++;
      $display("FAIL basic_w0: got %h/%b/%b expected %h/%b/%b",
               instruction, inst_valid, inst_fault, e.instr, e.valid, e.fault);
    end
    push_fetch(64'd4, '{32'h00700313, 1'b1, 1'b0});
    step();
    e = sb_q.pop_front();
    checks++;
    if ({instruction, inst_valid, inst_fault} !== {e.instr, e.valid, e.fault}) begin
      fails++;
      $display("FAIL basic_w1: got %h/%b/%b expected %h/%b/%b",
               instruction, inst_valid, inst_fault, e.instr, e.valid, e.fault);
    end
  endtask

  task automatic test_fault();
    logic [AW-1:0] addrs [4];
    exp_t e;
    addrs = '{64'd2, 64'd16, 64'd5, 64'd0};
    for (int k = 0; k < 4; k++) begin
      push_fetch(addrs[k], predict(addrs[k]));
      step();
      e = sb_q.pop_front();
      checks++;
      if ({instruction, inst_valid, inst_fault} !== {e.instr, e.valid, e.fault}) begin
        fails++;
        $display("FAIL fault_addr_%0h: got %h/%b/%b expected %h/%b/%b", addrs[k],
                 instruction, inst_valid, inst_fault, e.instr, e.valid, e.fault);
      end
    end
    fetch_req = 1'b0;
    sb_q.push_back('{NOP, 1'b0, 1'b0});
    step();
    e = sb_q.pop_front();
    checks++;
    if ({instruction, inst_valid, inst_fault} !== {e.instr, e.valid, e.fault}) begin
      fails++;
      $display("FAIL empty_slot: got %h/%b/%b expected %h/%b/%b",
               instruction, inst_valid, inst_fault, e.instr, e.valid, e.fault);
    end
  endtask

  task automatic test_stall();
    exp_t e, held;
    push_fetch(64'd0, predict(64'd0));
    step();
    held = sb_q.pop_front();
    checks++;
    if ({instruction, inst_valid, inst_fault} !== {held.instr, held.valid, held.fault}) begin
      fails++;
      $display("FAIL stall_pre: got %h/%b/%b expected %h/%b/%b",
               instruction, inst_valid, inst_fault, held.instr, held.valid, held.fault);
    end
    for (int k = 1; k <= 3; k++) begin
      fetch_req   = 1'b1;
      fetch_stall = 1'b1;
      fetch_addr  = AW'(k * 4);
      sb_q.push_back(held);
      step();
      e = sb_q.pop_front();
      checks++;
      if ({instruction, inst_valid, inst_fault} !== {e.instr, e.valid, e.fault}) begin
        fails++;
        $display("FAIL stall_hold_%0d: got %h/%b/%b expected %h/%b/%b", k,
                 instruction, inst_valid, inst_fault, e.instr, e.valid, e.fault);
      end
    end
    push_fetch(64'd4, predict(64'd4));
    step();
    e = sb_q.pop_front();
    checks++;
    if ({instruction, inst_valid, inst_fault} !== {e.instr, e.valid, e.fault}) begin
      fails++;
      $display("FAIL stall_release: got %h/%b/%b expected %h/%b/%b",
               instruction, inst_valid, inst_fault, e.instr, e.valid, e.fault);
    end
    fetch_req = 1'b0;
    step();
  endtask

  task automatic test_partial_last();
    logic [AW-1:0] addrs [2];
    logic [31:0]   want  [2];
    exp_t e;
    load_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAB};
    load_stream(5, 1'b1, 1'b1);
    step();
    addrs = '{64'd4, 64'd0};
    want  = '{32'h000000AB, 32'h44332211};
    for (int k = 0; k < 2; k++) begin
      push_fetch(addrs[k], '{want[k], 1'b1, 1'b0});
      step();
      e = sb_q.pop_front();
      checks++;
      if ({instruction, inst_valid, inst_fault} !== {e.instr, e.valid, e.fault}) begin
        fails++;
        $display("FAIL partial5_%0h: got %h/%b/%b expected %h/%b/%b", addrs[k],
                 instruction, inst_valid, inst_fault, e.instr, e.valid, e.fault);
      end
    end
    load_q = '{8'h5A};
    load_stream(1, 1'b1, 1'b1);
    step();
    want = '{32'h000000AB, 32'h0000005A};
    for (int k = 0; k < 2; k++) begin
      push_fetch(addrs[k], '{want[k], 1'b1, 1'b0});
      step();
      e = sb_q.pop_front();
      checks++;
      if ({instruction, inst_valid, inst_fault} !== {e.instr, e.valid, e.fault}) begin
        fails++;
        $display("FAIL partial1_%0h: got %h/%b/%b expected %h/%b/%b", addrs[k],
                 instruction, inst_valid, inst_fault, e.instr, e.valid, e.fault);
      end
    end
    fetch_req = 1'b0;
  endtask

  task automatic test_overflow();
    load_q.delete();
    for (int i = 0; i < 20; i++) load_q.push_back(8'hA0 + 8'(i));
    load_stream(20, 1'b1, 1'b0);
    step();
    checks++;
    if (ld_err !== 1'b1 || merr !== 1'b1) begin
      fails++;
      $display("FAIL overflow_err_sticky: got %b expected 1", ld_err);
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] addrs [5];
    logic [31:0]   want  [5];
    exp_t e;
    addrs = '{64'd0, 64'd4, 64'd8, 64'd12, 64'd0};
    want  = '{32'hA3A2A1A0, 32'hA7A6A5A4, 32'hABAAA9A8, 32'hAFAEADAC, 32'hA3A2A1A0};
    for (int k = 0; k < 5; k++) begin
      push_fetch(addrs[k], '{want[k], 1'b1, 1'b0});
      step();
      e = sb_q.pop_front();
      checks++;
      if ({instruction, inst_valid, inst_fault} !== {e.instr, e.valid, e.fault}) begin
        fails++;
        $display("FAIL b2b_%0d: got %h/%b/%b expected %h/%b/%b", k,
                 instruction, inst_valid, inst_fault, e.instr, e.valid, e.fault);
      end
    end
    fetch_req = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_load();
    logic [AW-1:0] addrs [2];
    logic [31:0]   want  [2];
    exp_t e;
    load_q = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
    load_stream(6, 1'b0, 1'b0);
    reset_n  = 1'b0;
    ld_valid = 1'b1;
    ld_byte  = 8'hEE;
    step();
    ld_valid = 1'b0;
    checks++;
    if ({ld_busy, ld_ready, ld_done, ld_err, inst_valid, instruction} !== {5'b00000, NOP}) begin
      fails++;
      $display("FAIL reset_mid_load: busy/ready/done/err/valid %b%b%b%b%b instr %h expected 00000 %h",
               ld_busy, ld_ready, ld_done, ld_err, inst_valid, instruction, NOP);
    end
    reset_n = 1'b1;
    step();
    addrs = '{64'd0, 64'd4};
    want  = '{32'hC3C2C1C0, 32'hA7A6A5A4};
    for (int k = 0; k < 2; k++) begin
      push_fetch(addrs[k], '{want[k], 1'b1, 1'b0});
      step();
      e = sb_q.pop_front();
      checks++;
      if ({instruction, inst_valid, inst_fault} !== {e.instr, e.valid, e.fault}) begin
        fails++;
        $display("FAIL after_reset_%0h: got %h/%b/%b expected %h/%b/%b", addrs[k],
                 instruction, inst_valid, inst_fault, e.instr, e.valid, e.fault);
      end
    end
    fetch_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_fault();
    test_stall();
    test_partial_last();
    test_overflow();
    test_back_to_back();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
